// File: rtl/tl_ul_channel_buffer_pkg.sv
// Shared TileLink-UL definitions for the channel buffer.
//  - A/D opcode encodings used by the buffer's users (the buffer never decodes them)
//  - field widths and helpers that derive packed bundle widths and occupancy widths
// Bundle layouts, MSB first:
//  A: {opcode3, param3, size3, source, address, mask(DATA_W/8), data, corrupt1}
//  D: {opcode3, param2, size3, source, sink1, denied1, data, corrupt1}
package tl_ul_channel_buffer_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned A_PARAM_W = 3;
  localparam int unsigned D_PARAM_W = 2;
  localparam int unsigned SIZE_W    = 3;

  function automatic int unsigned a_width(input int unsigned addr_w, input int unsigned data_w,
                                          input int unsigned src_w);
    return OPCODE_W + A_PARAM_W + SIZE_W + src_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  function automatic int unsigned d_width(input int unsigned data_w, input int unsigned src_w);
    return OPCODE_W + D_PARAM_W + SIZE_W + src_w + 1 + 1 + data_w + 1;
  endfunction

  // Occupancy counter width; a pass-through queue still exposes a 1-bit zero count.
  function automatic int unsigned count_width(input int unsigned depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_ul_channel_buffer_if.sv
// TileLink-UL A/D handshake bundle around the channel buffer.
//  a_i_*: A channel from the master into the buffer   a_o_*: A channel out to the slave
//  d_i_*: D channel from the slave into the buffer    d_o_*: D channel out to the master
// Modports:
//  slave  - the buffer's own view (consumes a_i/d_i, produces a_o/d_o)
//  master - the surrounding fabric's view (drives a_i/d_i, accepts a_o/d_o)
interface tl_ul_channel_buffer_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SRC_W  = 7
);
  import tl_ul_channel_buffer_pkg::*;

  localparam int unsigned A_W = a_width(ADDR_W, DATA_W, SRC_W);
  localparam int unsigned D_W = d_width(DATA_W, SRC_W);

  logic           a_i_valid;
  logic           a_i_ready;
  logic [A_W-1:0] a_i_bits;
  logic           a_o_valid;
  logic           a_o_ready;
  logic [A_W-1:0] a_o_bits;
  logic           d_i_valid;
  logic           d_i_ready;
  logic [D_W-1:0] d_i_bits;
  logic           d_o_valid;
  logic           d_o_ready;
  logic [D_W-1:0] d_o_bits;

  modport slave (
    input  a_i_valid, a_i_bits, a_o_ready, d_i_valid, d_i_bits, d_o_ready,
    output a_i_ready, a_o_valid, a_o_bits, d_i_ready, d_o_valid, d_o_bits
  );

  modport master (
    output a_i_valid, a_i_bits, a_o_ready, d_i_valid, d_i_bits, d_o_ready,
    input  a_i_ready, a_o_valid, a_o_bits, d_i_ready, d_o_valid, d_o_bits
  );

endinterface

// File: rtl/tl_ul_channel_buffer_queue.sv
// Generic valid/ready queue.
//  DEPTH=0 : combinational pass-through, count tied to zero
//  DEPTH>=1: circular buffer, pointers wrap at DEPTH-1 (any depth legal)
//  FLOW    : an empty queue presents its input on the output in the same cycle
//  PIPE    : a full queue accepts a beat when the output dequeues in the same cycle
// Ports: clock, reset (async active-low), i_valid/i_ready/i_bits (enqueue side),
//  o_valid/o_ready/o_bits (dequeue side), count (occupancy).
module tl_ul_channel_buffer_queue
  import tl_ul_channel_buffer_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 2,
  parameter bit          FLOW  = 1'b0,
  parameter bit          PIPE  = 1'b0,
  localparam int unsigned CW   = count_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [W-1:0]  i_bits,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [W-1:0]  o_bits,
  output logic [CW-1:0] count
);

  if (DEPTH == 0) begin : g_wire
    assign o_valid = i_valid;
    assign o_bits  = i_bits;
    assign i_ready = o_ready;
    assign count   = '0;
  end else begin : g_fifo
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          empty;
    logic          full;
    logic          enq;
    logic          deq;
    logic          bypass;
    logic          do_wr;
    logic          do_rd;

    always_comb begin
      empty   = (cnt == '0);
      full    = (cnt == CW'(DEPTH));
      o_valid = !empty || (FLOW && i_valid);
      o_bits  = (FLOW && empty) ? i_bits : mem[rd_ptr];
      i_ready = !full || (PIPE && o_ready);
      enq     = i_valid && i_ready;
      deq     = o_valid && o_ready;
      // A beat that flows straight through an empty queue never touches storage.
      bypass  = FLOW && empty && deq;
      do_wr   = enq && !bypass;
      do_rd   = deq && !bypass;
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
        else if (do_rd && !do_wr) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= i_bits;
    end

    assign count = cnt;
  end

  count_in_range: assert property (@(posedge clock) disable iff (!reset)
    count <= CW'(DEPTH));

  input_held: assert property (@(posedge clock) disable iff (!reset)
    (i_valid && !i_ready) |=> $stable(i_bits));

endmodule

// File: rtl/tl_ul_channel_buffer.sv
// TileLink-UL A/D channel buffer between a master port and a slave port.
// Ports: clock, reset (async active-low), bus (A/D handshakes, slave modport),
//  a_count/d_count (queue occupancy), idle (both queues empty and no input offered).
// A and D use independent queues; bundle contents are never inspected.
module tl_ul_channel_buffer
  import tl_ul_channel_buffer_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRC_W   = 7,
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter bit          FLOW    = 1'b0,
  parameter bit          PIPE    = 1'b0,
  localparam int unsigned A_W    = a_width(ADDR_W, DATA_W, SRC_W),
  localparam int unsigned D_W    = d_width(DATA_W, SRC_W),
  localparam int unsigned CW_A   = count_width(A_DEPTH),
  localparam int unsigned CW_D   = count_width(D_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_ul_channel_buffer_if.slave bus,
  output logic [CW_A-1:0]       a_count,
  output logic [CW_D-1:0]       d_count,
  output logic                  idle
);

  tl_ul_channel_buffer_queue #(.W(A_W), .DEPTH(A_DEPTH), .FLOW(FLOW), .PIPE(PIPE)) u_a_queue (
    .clock  (clock),
    .reset  (reset),
    .i_valid(bus.a_i_valid),
    .i_ready(bus.a_i_ready),
    .i_bits (bus.a_i_bits),
    .o_valid(bus.a_o_valid),
    .o_ready(bus.a_o_ready),
    .o_bits (bus.a_o_bits),
    .count  (a_count)
  );

  tl_ul_channel_buffer_queue #(.W(D_W), .DEPTH(D_DEPTH), .FLOW(FLOW), .PIPE(PIPE)) u_d_queue (
    .clock  (clock),
    .reset  (reset),
    .i_valid(bus.d_i_valid),
    .i_ready(bus.d_i_ready),
    .i_bits (bus.d_i_bits),
    .o_valid(bus.d_o_valid),
    .o_ready(bus.d_o_ready),
    .o_bits (bus.d_o_bits),
    .count  (d_count)
  );

  assign idle = (a_count == '0) && (d_count == '0) && !bus.a_i_valid && !bus.d_i_valid;

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
// Bench for tl_ul_channel_buffer, three instances:
//  u0: A pass-through, D depth 3 with FLOW
//  u1: A/D depth 2, no FLOW/PIPE, own reset (used for the mid-stream reset sequence)
//  u2: A depth 1 with PIPE, D depth 3 with PIPE (random traffic on D)
module tb_tl_ul_channel_buffer;
  import tl_ul_channel_buffer_pkg::*;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 7;
  localparam int unsigned A_W    = a_width(ADDR_W, DATA_W, SRC_W);
  localparam int unsigned D_W    = d_width(DATA_W, SRC_W);
  localparam int unsigned NB     = 10000;

  logic clock;
  logic rst0;
  logic rst1;
  int   errors;
  int   checks;

  logic [0:0] c0a;
  logic [1:0] c0d;
  logic [1:0] c1a;
  logic [1:0] c1d;
  logic [0:0] c2a;
  logic [1:0] c2d;
  logic       idle0;
  logic       idle1;
  logic       idle2;

  tl_ul_channel_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) if0 ();
  tl_ul_channel_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) if1 ();
  tl_ul_channel_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) if2 ();

  tl_ul_channel_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W),
    .A_DEPTH(0), .D_DEPTH(3), .FLOW(1'b1), .PIPE(1'b0)
  ) u0 (.clock(clock), .reset(rst0), .bus(if0), .a_count(c0a), .d_count(c0d), .idle(idle0));

  tl_ul_channel_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W),
    .A_DEPTH(2), .D_DEPTH(2), .FLOW(1'b0), .PIPE(1'b0)
  ) u1 (.clock(clock), .reset(rst1), .bus(if1), .a_count(c1a), .d_count(c1d), .idle(idle1));

  tl_ul_channel_buffer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W),
    .A_DEPTH(1), .D_DEPTH(3), .FLOW(1'b0), .PIPE(1'b1)
  ) u2 (.clock(clock), .reset(rst0), .bus(if2), .a_count(c2a), .d_count(c2d), .idle(idle2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [A_W-1:0] mk_a(input a_opcode_e op, input logic [SRC_W-1:0] src,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W/8-1:0] mask,
                                          input logic [DATA_W-1:0] data);
    return {op, 3'd0, 3'd2, src, addr, mask, data, 1'b0};
  endfunction

  function automatic logic [D_W-1:0] mk_d(input d_opcode_e op, input int unsigned i,
                                          input logic [DATA_W-1:0] data);
    return {op, 2'(i), 3'd2, SRC_W'(i), 1'b0, 1'b0, data, 1'b0};
  endfunction

  function automatic logic [A_W-1:0] pa(input int unsigned n);
    return mk_a(PUT_FULL, SRC_W'(n), ADDR_W'(32'h100 + n * 4), 4'hF, 32'(n * 3 + 7));
  endfunction

  function automatic logic [D_W-1:0] rd(input int unsigned n);
    return mk_d(ACCESS_ACK_DATA, n, 32'(n * 32'h9E37_79B9 + 1));
  endfunction

  typedef struct {
    logic            v;
    logic            r;
    a_opcode_e       op;
    logic [29:0]     addr;
    logic [6:0]      src;
    logic [3:0]      mask;
    logic [31:0]     data;
    logic            e_ov;
    logic            e_ir;
    logic            e_idle;
  } vec_t;

  vec_t tbl[8];

  task automatic directed();
    // Pass-through A channel on u0: everything is combinational, zero latency.
    tbl[0] = '{1'b0, 1'b1, GET,         30'h1000_0000, 7'd5,   4'hF, 32'h0,         1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b1, GET,         30'h1000_0000, 7'd5,   4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, GET,         30'h1000_0000, 7'd5,   4'hF, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, GET,         30'h1000_0000, 7'd5,   4'hF, 32'h0,         1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, GET,         30'h1000_0000, 7'd5,   4'hF, 32'h0,         1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, PUT_FULL,    30'h3FFF_FFFC, 7'd127, 4'hF, 32'hA5A5_5A5A, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, PUT_PARTIAL, 30'h0,         7'd0,   4'h5, 32'h0102_0304, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, PUT_PARTIAL, 30'h0,         7'd0,   4'h5, 32'h0102_0304, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if0.a_i_valid = tbl[i].v;
      if0.a_o_ready = tbl[i].r;
      if0.a_i_bits  = mk_a(tbl[i].op, tbl[i].src, tbl[i].addr, tbl[i].mask, tbl[i].data);
      #1;
      chk($sformatf("t1_o_valid[%0d]", i), 128'(if0.a_o_valid), 128'(tbl[i].e_ov));
      chk($sformatf("t1_i_ready[%0d]", i), 128'(if0.a_i_ready), 128'(tbl[i].e_ir));
      chk($sformatf("t1_o_bits[%0d]", i), 128'(if0.a_o_bits),
          128'(mk_a(tbl[i].op, tbl[i].src, tbl[i].addr, tbl[i].mask, tbl[i].data)));
      chk($sformatf("t1_idle[%0d]", i), 128'(idle0), 128'(tbl[i].e_idle));
      chk($sformatf("t1_count[%0d]", i), 128'(c0a), 128'(0));
    end

    // D FLOW on u0: bypass with dequeue, then bypass without dequeue.
    @(negedge clock);
    if0.d_i_valid = 1'b1;
    if0.d_i_bits  = mk_d(ACCESS_ACK_DATA, 3, 32'hDEAD_BEEF);
    if0.d_o_ready = 1'b1;
    #1;
    chk("t3_o_valid", 128'(if0.d_o_valid), 128'(1));
    chk("t3_o_bits", 128'(if0.d_o_bits), 128'(mk_d(ACCESS_ACK_DATA, 3, 32'hDEAD_BEEF)));
    chk("t3_i_ready", 128'(if0.d_i_ready), 128'(1));
    chk("t3_idle", 128'(idle0), 128'(0));
    @(negedge clock);
    if0.d_i_bits  = mk_d(ACCESS_ACK, 1, 32'h1234_5678);
    if0.d_o_ready = 1'b0;
    #1;
    chk("t3_count_bypass", 128'(c0d), 128'(0));
    chk("t3_flow_valid", 128'(if0.d_o_valid), 128'(1));
    chk("t3_flow_bits", 128'(if0.d_o_bits), 128'(mk_d(ACCESS_ACK, 1, 32'h1234_5678)));
    @(negedge clock);
    if0.d_i_valid = 1'b0;
    #1;
    chk("t3_count_stored", 128'(c0d), 128'(1));
    chk("t3_stored_bits", 128'(if0.d_o_bits), 128'(mk_d(ACCESS_ACK, 1, 32'h1234_5678)));
    @(negedge clock);
    if0.d_o_ready = 1'b1;
    #1;
    chk("t3_stored_valid", 128'(if0.d_o_valid), 128'(1));
    @(negedge clock);
    if0.d_o_ready = 1'b0;
    #1;
    chk("t3_drained_count", 128'(c0d), 128'(0));
    chk("t3_drained_valid", 128'(if0.d_o_valid), 128'(0));
    chk("t3_drained_idle", 128'(idle0), 128'(1));

    // Depth-2 A on u1 with backpressure: fill, full stall, drain in order.
    @(negedge clock);
    if1.a_o_ready = 1'b0;
    if1.a_i_valid = 1'b1;
    if1.a_i_bits  = pa(1);
    #1;
    chk("t2_ready_empty", 128'(if1.a_i_ready), 128'(1));
    @(negedge clock);
    if1.a_i_bits = pa(2);
    #1;
    chk("t2_o_valid", 128'(if1.a_o_valid), 128'(1));
    chk("t2_head1", 128'(if1.a_o_bits), 128'(pa(1)));
    chk("t2_count1", 128'(c1a), 128'(1));
    chk("t2_ready_one", 128'(if1.a_i_ready), 128'(1));
    @(negedge clock);
    if1.a_i_bits = pa(3);
    #1;
    chk("t2_count2", 128'(c1a), 128'(2));
    chk("t2_full_ready", 128'(if1.a_i_ready), 128'(0));
    if1.a_o_ready = 1'b1;
    #1;
    chk("t2_full_ready_oready", 128'(if1.a_i_ready), 128'(0));
    chk("t2_out1", 128'(if1.a_o_bits), 128'(pa(1)));
    @(negedge clock);
    #1;
    chk("t2_out2", 128'(if1.a_o_bits), 128'(pa(2)));
    chk("t2_count_after1", 128'(c1a), 128'(1));
    chk("t2_ready_again", 128'(if1.a_i_ready), 128'(1));
    @(negedge clock);
    if1.a_i_valid = 1'b0;
    #1;
    chk("t2_out3", 128'(if1.a_o_bits), 128'(pa(3)));
    chk("t2_count_simul", 128'(c1a), 128'(1));
    @(negedge clock);
    if1.a_o_ready = 1'b0;
    #1;
    chk("t2_empty_valid", 128'(if1.a_o_valid), 128'(0));
    chk("t2_empty_count", 128'(c1a), 128'(0));
    chk("t2_idle", 128'(idle1), 128'(1));

    // Reset u1 while holding two A beats.
    @(negedge clock);
    if1.a_i_valid = 1'b1;
    if1.a_i_bits  = pa(4);
    @(negedge clock);
    if1.a_i_bits = pa(5);
    @(negedge clock);
    if1.a_i_valid = 1'b0;
    #1;
    chk("t6_count_before", 128'(c1a), 128'(2));
    chk("t6_valid_before", 128'(if1.a_o_valid), 128'(1));
    rst1 = 1'b0;
    #1;
    chk("t6_valid_reset", 128'(if1.a_o_valid), 128'(0));
    chk("t6_count_reset", 128'(c1a), 128'(0));
    chk("t6_dcount_reset", 128'(c1d), 128'(0));
    chk("t6_ready_reset", 128'(if1.a_i_ready), 128'(1));
    chk("t6_idle_reset", 128'(idle1), 128'(1));
    @(negedge clock);
    rst1 = 1'b1;
    if1.a_i_valid = 1'b1;
    if1.a_i_bits  = pa(6);
    @(negedge clock);
    if1.a_i_valid = 1'b0;
    #1;
    chk("t6_after_valid", 128'(if1.a_o_valid), 128'(1));
    chk("t6_after_bits", 128'(if1.a_o_bits), 128'(pa(6)));
    chk("t6_after_count", 128'(c1a), 128'(1));
    if1.a_o_ready = 1'b1;
    @(negedge clock);
    #1;
    chk("t6_after_drain", 128'(c1a), 128'(0));
    chk("t6_after_o_valid", 128'(if1.a_o_valid), 128'(0));

    // Depth-1 PIPE A on u2: full stall without dequeue, then one beat per cycle.
    @(negedge clock);
    if2.a_o_ready = 1'b0;
    if2.a_i_valid = 1'b1;
    if2.a_i_bits  = pa(0);
    #1;
    chk("t4_ready_empty", 128'(if2.a_i_ready), 128'(1));
    @(negedge clock);
    if2.a_i_bits = pa(1);
    #1;
    chk("t4_full_no_deq", 128'(if2.a_i_ready), 128'(0));
    chk("t4_count_full", 128'(c2a), 128'(1));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if2.a_o_ready = 1'b1;
      if2.a_i_bits  = pa(k);
      #1;
      chk($sformatf("t4_ready[%0d]", k), 128'(if2.a_i_ready), 128'(1));
      chk($sformatf("t4_bits[%0d]", k), 128'(if2.a_o_bits), 128'(pa(k - 1)));
      chk($sformatf("t4_count[%0d]", k), 128'(c2a), 128'(1));
    end
    @(negedge clock);
    if2.a_i_valid = 1'b0;
    #1;
    chk("t4_last_bits", 128'(if2.a_o_bits), 128'(pa(16)));
    @(negedge clock);
    #1;
    chk("t4_drained_valid", 128'(if2.a_o_valid), 128'(0));
    chk("t4_drained_count", 128'(c2a), 128'(0));
  endtask

  task automatic random_d();
    int unsigned sent;
    int unsigned rcvd;
    bit          hold;
    sent = 0;
    rcvd = 0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 60000 && rcvd < NB; cyc++) begin
      @(negedge clock);
      if (!hold) begin
        if2.d_i_valid = (sent < NB) && ($urandom_range(3) != 0);
        if (if2.d_i_valid) if2.d_i_bits = rd(sent);
      end
      if2.d_o_ready = ($urandom_range(3) != 0);
      #1;
      if (if2.d_o_valid && if2.d_o_ready) begin
        chk($sformatf("t5_beat[%0d]", rcvd), 128'(if2.d_o_bits), 128'(rd(rcvd)));
        rcvd++;
      end
      if (if2.d_i_valid && if2.d_i_ready) begin
        sent++;
        hold = 1'b0;
      end else begin
        hold = if2.d_i_valid;
      end
    end
    @(negedge clock);
    if2.d_i_valid = 1'b0;
    if2.d_o_ready = 1'b1;
    #1;
    chk("t5_received", 128'(rcvd), 128'(NB));
    chk("t5_no_extra_valid", 128'(if2.d_o_valid), 128'(0));
    chk("t5_no_extra_count", 128'(c2d), 128'(0));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst0 = 1'b0;
    rst1 = 1'b0;
    if0.a_i_valid = 1'b0; if0.a_i_bits = '0; if0.a_o_ready = 1'b0;
    if0.d_i_valid = 1'b0; if0.d_i_bits = '0; if0.d_o_ready = 1'b0;
    if1.a_i_valid = 1'b0; if1.a_i_bits = '0; if1.a_o_ready = 1'b0;
    if1.d_i_valid = 1'b0; if1.d_i_bits = '0; if1.d_o_ready = 1'b0;
    if2.a_i_valid = 1'b0; if2.a_i_bits = '0; if2.a_o_ready = 1'b0;
    if2.d_i_valid = 1'b0; if2.d_i_bits = '0; if2.d_o_ready = 1'b0;
    #12;
    chk("rst_u1_a_o_valid", 128'(if1.a_o_valid), 128'(0));
    chk("rst_u1_d_o_valid", 128'(if1.d_o_valid), 128'(0));
    chk("rst_u1_a_i_ready", 128'(if1.a_i_ready), 128'(1));
    chk("rst_u1_d_i_ready", 128'(if1.d_i_ready), 128'(1));
    chk("rst_u1_counts", 128'({c1a, c1d}), 128'(0));
    chk("rst_u1_idle", 128'(idle1), 128'(1));
    chk("rst_u2_a_i_ready", 128'(if2.a_i_ready), 128'(1));
    chk("rst_u2_counts", 128'({c2a, c2d}), 128'(0));
    chk("rst_u0_d_o_valid", 128'(if0.d_o_valid), 128'(0));
    chk("rst_u0_d_i_ready", 128'(if0.d_i_ready), 128'(1));
    @(negedge clock);
    rst0 = 1'b1;
    rst1 = 1'b1;
    fork
      directed();
      random_d();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
